// File: rtl/bid_engine_n_pkg.sv
// rtl/bid_engine_n_pkg.sv - shared opcode, error and state encodings for the bid engine
package bids22defs;

    typedef enum logic [3:0] {
        OP_NOP          = 4'd0,
        OP_LOCK         = 4'd1,
        OP_UNLOCK       = 4'd2,
        OP_LOAD         = 4'd3,
        OP_SETMASK      = 4'd4,
        OP_SETTIMER     = 4'd5,
        OP_SETBIDCHARGE = 4'd6
    } op_e;

    typedef enum logic [2:0] {
        NOERROR            = 3'd0,
        CSTARTWHENUNLOCKED = 3'd1,
        ALREADYUNLOCKED    = 3'd2,
        INVALID_OP         = 3'd3,
        BADKEY             = 3'd4,
        DUPLICATEBIDS      = 3'd5
    } err_e;

    typedef enum logic [1:0] {
        NOBIDERROR        = 2'd0,
        INVALIDREQUEST    = 2'd1,
        INSUFFICIENTFUNDS = 2'd2
    } bid_err_e;

    typedef enum logic [2:0] {
        ST_UNLOCKED = 3'd0,
        ST_LOCKED   = 3'd1,
        ST_COOLDOWN = 3'd2,
        ST_ROUND    = 3'd3,
        ST_RESOLVE  = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

endpackage

// File: rtl/bid_engine_n_slot.sv
// rtl/bid_engine_n_slot.sv - one bidder: balance, last live bid and bid acceptance
module bidder_slot
    import bids22defs::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_round,
    input  logic                 i_bid,
    input  logic [DATAWIDTH-1:0] i_amt,
    input  logic                 i_retract,
    input  logic                 i_mask,
    input  logic [DATAWIDTH-1:0] i_charge,
    input  logic                 i_load,
    input  logic [DATAWIDTH-1:0] i_load_data,
    input  logic                 i_debit,
    input  logic                 i_clear,
    output logic [DATAWIDTH-1:0] o_value,
    output logic [DATAWIDTH-1:0] o_lastbid,
    output logic                 o_ack,
    output logic [1:0]           o_bid_err
);

    logic [DATAWIDTH-1:0] r_value;
    logic [DATAWIDTH-1:0] r_lastbid;
    logic [DATAWIDTH:0]   w_need;

    // One extra bit so amount plus charge cannot wrap past the balance
    assign w_need = {1'b0, i_amt} + {1'b0, i_charge};

    // Accept or reject a bid in the cycle it is presented
    always_comb begin
        o_ack     = 1'b0;
        o_bid_err = NOBIDERROR;
        if (i_round && i_bid) begin
            if (!i_mask) begin
                o_bid_err = INVALIDREQUEST;
            end else if (w_need > {1'b0, r_value}) begin
                o_bid_err = INSUFFICIENTFUNDS;
            end else begin
                o_ack = 1'b1;
            end
        end
    end

    // Balance: load, per-bid charge, or winner debit (debit uses the pre-clear lastbid)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_value <= '0;
        end else if (i_load) begin
            r_value <= i_load_data;
        end else if (o_ack) begin
            r_value <= r_value - i_charge;
        end else if (i_debit) begin
            r_value <= r_value - r_lastbid;
        end
    end

    // Last live bid: a bid beats a simultaneous retract
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lastbid <= '0;
        end else if (i_clear) begin
            r_lastbid <= '0;
        end else if (o_ack) begin
            r_lastbid <= i_amt;
        end else if (i_round && i_retract && !i_bid) begin
            r_lastbid <= '0;
        end
    end

    assign o_value   = r_value;
    assign o_lastbid = r_lastbid;

endmodule

// File: rtl/bid_engine_n.sv
// rtl/bid_engine_n.sv - sealed-round auction controller with per-bidder balances
module bid_engine_n
    import bids22defs::*;
#(
    parameter int DATAWIDTH  = 32,
    parameter int NUMBIDDERS = 4,
    parameter int IDW        = $clog2(NUMBIDDERS)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUMBIDDERS-1:0]           bid,
    input  logic [NUMBIDDERS*DATAWIDTH-1:0] bid_amt,
    input  logic [NUMBIDDERS-1:0]           retract,
    input  logic [3:0]                      c_op,
    input  logic [DATAWIDTH-1:0]            c_data,
    input  logic [IDW-1:0]                  c_sel,
    input  logic                            c_start,
    output logic [NUMBIDDERS-1:0]           bid_ack,
    output logic [NUMBIDDERS*2-1:0]         bid_err,
    output logic [NUMBIDDERS*DATAWIDTH-1:0] balance,
    output logic [NUMBIDDERS-1:0]           win,
    output logic [IDW-1:0]                  winner_id,
    output logic [DATAWIDTH-1:0]            max_bid,
    output logic                            round_over,
    output logic                            ready,
    output logic [2:0]                      err
);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [DATAWIDTH-1:0]  r_key;
    logic [NUMBIDDERS-1:0] r_mask;
    logic [DATAWIDTH-1:0]  r_reload;
    logic [DATAWIDTH-1:0]  r_timer;
    logic [DATAWIDTH-1:0]  r_charge;
    logic [IDW-1:0]        r_idx;
    logic [DATAWIDTH-1:0]  r_best;
    logic [IDW-1:0]        r_best_id;
    logic [NUMBIDDERS-1:0] r_res_win;
    logic [IDW-1:0]        r_res_id;
    logic [DATAWIDTH-1:0]  r_res_max;

    logic [DATAWIDTH-1:0]  w_lastbid [NUMBIDDERS];
    logic                  w_in_round;
    logic                  w_in_done;
    logic                  w_unlocked_op;
    logic                  w_load_en;
    logic                  w_round_entry;
    logic                  w_bad_unlock;
    logic                  w_scan_last;
    logic                  w_scan_take;
    logic [DATAWIDTH-1:0]  w_next_best;
    logic [IDW-1:0]        w_next_id;
    logic                  w_dup;
    logic [DATAWIDTH-1:0]  w_round_max;
    err_e                  w_err;

    assign w_in_round    = (r_state == ST_ROUND);
    assign w_in_done     = (r_state == ST_DONE);
    assign w_unlocked_op = (r_state == ST_UNLOCKED);
    assign w_load_en     = w_unlocked_op && (c_op == OP_LOAD);
    assign w_round_entry = (r_state == ST_LOCKED) && c_start;
    assign w_bad_unlock  = (r_state == ST_LOCKED) && !c_start &&
                           (c_op == OP_UNLOCK) && (c_data != r_key);
    assign w_scan_last   = (r_idx == IDW'(NUMBIDDERS - 1));
    assign w_scan_take   = (w_lastbid[r_idx] > r_best);
    assign w_next_best   = w_scan_take ? w_lastbid[r_idx] : r_best;
    assign w_next_id     = w_scan_take ? r_idx : r_best_id;

    for (genvar g = 0; g < NUMBIDDERS; g++) begin : g_slot
        bidder_slot #(.DATAWIDTH(DATAWIDTH)) u_slot (
            .clk         (clk),
            .reset_n     (reset_n),
            .i_round     (w_in_round),
            .i_bid       (bid[g]),
            .i_amt       (bid_amt[g*DATAWIDTH +: DATAWIDTH]),
            .i_retract   (retract[g]),
            .i_mask      (r_mask[g]),
            .i_charge    (r_charge),
            .i_load      (w_load_en && (c_sel == IDW'(g))),
            .i_load_data (c_data),
            .i_debit     (w_in_done && r_res_win[g]),
            .i_clear     (w_in_done),
            .o_value     (balance[g*DATAWIDTH +: DATAWIDTH]),
            .o_lastbid   (w_lastbid[g]),
            .o_ack       (bid_ack[g]),
            .o_bid_err   (bid_err[2*g +: 2])
        );
    end

    // Flag any two accepted bids of the same amount in one cycle
    always_comb begin
        w_dup = 1'b0;
        for (int i = 0; i < NUMBIDDERS; i++) begin
            for (int j = i + 1; j < NUMBIDDERS; j++) begin
                if (bid_ack[i] && bid_ack[j] &&
                    (bid_amt[i*DATAWIDTH +: DATAWIDTH] == bid_amt[j*DATAWIDTH +: DATAWIDTH])) begin
                    w_dup = 1'b1;
                end
            end
        end
    end

    // Live maximum of all standing bids, shown while the round is open
    always_comb begin
        w_round_max = '0;
        for (int i = 0; i < NUMBIDDERS; i++) begin
            if (w_lastbid[i] > w_round_max) begin
                w_round_max = w_lastbid[i];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_UNLOCKED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and controller error code
    always_comb begin
        w_state_nxt = r_state;
        w_err       = NOERROR;
        case (r_state)
            ST_UNLOCKED: begin
                case (c_op)
                    OP_UNLOCK:  w_err = ALREADYUNLOCKED;
                    OP_NOP, OP_LOCK, OP_LOAD, OP_SETMASK,
                    OP_SETTIMER, OP_SETBIDCHARGE: w_err = NOERROR;
                    default:    w_err = INVALID_OP;
                endcase
                if (c_start) begin
                    w_err = CSTARTWHENUNLOCKED;
                end
                if (c_op == OP_LOCK) begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (c_start) begin
                    w_state_nxt = ST_ROUND;
                end else if (c_op == OP_UNLOCK) begin
                    w_state_nxt = (c_data == r_key) ? ST_UNLOCKED : ST_COOLDOWN;
                end
            end
            ST_COOLDOWN: begin
                w_err = BADKEY;
                if (r_timer == '0) begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_ROUND: begin
                if (w_dup) begin
                    w_err = DUPLICATEBIDS;
                end
                if (!c_start) begin
                    w_state_nxt = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                if (w_scan_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_LOCKED;
            end
            default: begin
                w_state_nxt = ST_UNLOCKED;
            end
        endcase
    end

    // Configuration registers written only while unlocked
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_key    <= '0;
            r_mask   <= '1;
            r_reload <= DATAWIDTH'(15);
            r_charge <= DATAWIDTH'(1);
        end else if (w_unlocked_op) begin
            case (c_op)
                OP_LOCK:         r_key    <= c_data;
                OP_SETMASK:      r_mask   <= c_data[NUMBIDDERS-1:0];
                OP_SETTIMER:     r_reload <= c_data;
                OP_SETBIDCHARGE: r_charge <= c_data;
                default:         ;
            endcase
        end
    end

    // Lockout timer: armed by a wrong key, counts down through cooldown
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timer <= DATAWIDTH'(15);
        end else if (w_bad_unlock) begin
            r_timer <= r_reload;
        end else if ((r_state == ST_COOLDOWN) && (r_timer != '0)) begin
            r_timer <= r_timer - DATAWIDTH'(1);
        end
    end

    // Winner scan, one bidder per cycle; results held until the next round opens
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx     <= '0;
            r_best    <= '0;
            r_best_id <= '0;
            r_res_win <= '0;
            r_res_id  <= '0;
            r_res_max <= '0;
        end else if (w_round_entry) begin
            r_idx     <= '0;
            r_best    <= '0;
            r_best_id <= '0;
            r_res_win <= '0;
            r_res_id  <= '0;
            r_res_max <= '0;
        end else if (r_state == ST_RESOLVE) begin
            r_best    <= w_next_best;
            r_best_id <= w_next_id;
            if (w_scan_last) begin
                r_idx     <= '0;
                r_res_max <= w_next_best;
                r_res_id  <= (w_next_best != '0) ? w_next_id : '0;
                r_res_win <= (w_next_best != '0) ? (NUMBIDDERS'(1) << w_next_id) : '0;
            end else begin
                r_idx <= r_idx + IDW'(1);
            end
        end
    end

    assign win        = r_res_win;
    assign winner_id  = r_res_id;
    assign max_bid    = w_in_round ? w_round_max : r_res_max;
    assign round_over = w_in_done;
    assign ready      = (r_state != ST_RESOLVE);
    assign err        = reset_n ? w_err : NOERROR;

endmodule

// File: tb/tb_bid_engine_n.sv
// tb/tb_bid_engine_n.sv - scoreboard bench for bid_engine_n
module tb_bid_engine_n;
    import bids22defs::*;

    localparam int DW  = 32;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N-1:0]      bid;
    logic [N*DW-1:0]   bid_amt;
    logic [N-1:0]      retract;
    logic [3:0]        c_op;
    logic [DW-1:0]     c_data;
    logic [IDW-1:0]    c_sel;
    logic              c_start;
    logic [N-1:0]      bid_ack;
    logic [N*2-1:0]    bid_err;
    logic [N*DW-1:0]   balance;
    logic [N-1:0]      win;
    logic [IDW-1:0]    winner_id;
    logic [DW-1:0]     max_bid;
    logic              round_over;
    logic              ready;
    logic [2:0]        err;

    int                n_checks = 0;
    int                n_errors = 0;
    string             sb_tag [$];
    logic [63:0]       sb_exp [$];
    logic [DW-1:0]     exp_bal [N];

    always #5 clk = ~clk;

    bid_engine_n #(.DATAWIDTH(DW), .NUMBIDDERS(N), .IDW(IDW)) dut (
        .clk(clk), .reset_n(reset_n), .bid(bid), .bid_amt(bid_amt),
        .retract(retract), .c_op(c_op), .c_data(c_data), .c_sel(c_sel),
        .c_start(c_start), .bid_ack(bid_ack), .bid_err(bid_err),
        .balance(balance), .win(win), .winner_id(winner_id),
        .max_bid(max_bid), .round_over(round_over), .ready(ready), .err(err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [63:0] v);
        sb_tag.push_back(tag);
        sb_exp.push_back(v);
    endtask

    task automatic sb_pop(input logic [63:0] obs);
        string       t;
        logic [63:0] e;
        if (sb_exp.size() == 0) begin
            check("sb_underflow", 64'(sb_exp.size()), 64'd1);
        end else begin
            t = sb_tag.pop_front();
            e = sb_exp.pop_front();
            check(t, obs, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bal(input string tag);
        for (int i = 0; i < N; i++) sb_push($sformatf("%s_bal%0d", tag, i), 64'(exp_bal[i]));
        for (int i = 0; i < N; i++) sb_pop(64'(balance[i*DW +: DW]));
    endtask

    task automatic check_state(input string tag, input state_e s);
        check(tag, 64'(dut.r_state), 64'(s));
    endtask

    task automatic op(input logic [3:0] o, input logic [DW-1:0] d, input logic [IDW-1:0] s);
        c_op = o; c_data = d; c_sel = s;
        tick();
        c_op = OP_NOP; c_data = '0; c_sel = '0;
    endtask

    // Close the round and compare the result strobe against the queued expectation
    task automatic run_resolve(input string tag, input logic [N-1:0] ew,
                               input logic [IDW-1:0] eid, input logic [DW-1:0] emax);
        int low = 0;
        int cyc = 0;
        sb_push({tag, "_win"}, 64'(ew));
        sb_push({tag, "_id"}, 64'(eid));
        sb_push({tag, "_max"}, 64'(emax));
        c_start = 1'b0;
        tick();
        while (!round_over && cyc < 20) begin
            if (!ready) low++;
            tick();
            cyc++;
        end
        check({tag, "_round_over"}, 64'(round_over), 64'd1);
        check({tag, "_resolve_cycles"}, 64'(low), 64'(N));
        sb_pop(64'(win));
        sb_pop(64'(winner_id));
        sb_pop(64'(max_bid));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] vals [N];
        int bad;
        vals[0] = 100; vals[1] = 50; vals[2] = 80; vals[3] = 20;
        reset_n = 1'b0; bid = '0; bid_amt = '0; retract = '0;
        c_op = OP_NOP; c_data = '0; c_sel = '0; c_start = 1'b0;
        for (int i = 0; i < N; i++) exp_bal[i] = '0;
        repeat (3) tick();

        check_bal("rst");
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_win", 64'(win), 64'd0);
        check("rst_max", 64'(max_bid), 64'd0);
        check("rst_round_over", 64'(round_over), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check_state("rst_state", ST_UNLOCKED);

        reset_n = 1'b1;
        tick();
        c_op = OP_UNLOCK; #1;
        check("err_already", 64'(err), 64'(ALREADYUNLOCKED));
        c_op = 4'hF; #1;
        check("err_invalid", 64'(err), 64'(INVALID_OP));
        c_start = 1'b1; #1;
        check("err_cstart", 64'(err), 64'(CSTARTWHENUNLOCKED));
        c_start = 1'b0; c_op = OP_NOP;
        tick();
        check_state("still_unlocked", ST_UNLOCKED);

        for (int i = 0; i < N; i++) begin
            op(OP_LOAD, vals[i], IDW'(i));
            exp_bal[i] = vals[i];
        end
        op(OP_LOCK, 32'hA5, '0);
        check_bal("load");
        check_state("locked", ST_LOCKED);

        // Round 1: tied bids from 0 and 2, lowest index wins
        c_start = 1'b1;
        tick();
        check_state("round1", ST_ROUND);
        bid = 4'b0101;
        bid_amt[0*DW +: DW] = 40;
        bid_amt[2*DW +: DW] = 40;
        #1;
        check("r1_err_dup", 64'(err), 64'(DUPLICATEBIDS));
        check("r1_ack", 64'(bid_ack), 64'h5);
        check("r1_bid_err", 64'(bid_err), 64'h0);
        tick();
        bid = '0; bid_amt = '0;
        exp_bal[0] -= 1; exp_bal[2] -= 1;
        check_bal("r1_charge");
        check("r1_live_max", 64'(max_bid), 64'd40);
        run_resolve("r1", 4'b0001, 2'd0, 32'd40);
        tick();
        exp_bal[0] -= 40;
        check_bal("r1_debit");
        check("r1_hold_win", 64'(win), 64'h1);
        check("r1_hold_max", 64'(max_bid), 64'd40);
        check_state("r1_locked", ST_LOCKED);

        // Round 2: insufficient funds, then bid and retract leaves no winner
        c_start = 1'b1;
        tick();
        check("r2_win_cleared", 64'(win), 64'd0);
        bid = 4'b1010;
        bid_amt[3*DW +: DW] = 20;
        bid_amt[1*DW +: DW] = 10;
        #1;
        check("r2_bid_err", 64'(bid_err), 64'h80);
        check("r2_ack", 64'(bid_ack), 64'h2);
        tick();
        bid = '0; bid_amt = '0;
        exp_bal[1] -= 1;
        retract = 4'b0010;
        #1;
        check("r2_live_max", 64'(max_bid), 64'd10);
        tick();
        retract = '0;
        #1;
        check("r2_retracted_max", 64'(max_bid), 64'd0);
        check_bal("r2_bal");
        run_resolve("r2", 4'b0000, 2'd0, 32'd0);
        tick();
        check_bal("r2_nodebit");

        // Cooldown after a wrong key, with ops and c_start ignored
        op(OP_UNLOCK, 32'hA5, '0);
        check_state("unlocked_again", ST_UNLOCKED);
        op(OP_SETTIMER, 32'd3, '0);
        op(OP_SETMASK, 32'hD, '0);
        op(OP_LOCK, 32'hA5, '0);
        op(OP_UNLOCK, 32'h11, '0);
        bad = 0;
        c_op = OP_LOAD; c_data = 32'd999; c_sel = '0; c_start = 1'b1;
        while (err == BADKEY && bad < 20) begin
            bad++;
            tick();
        end
        c_op = OP_NOP; c_data = '0; c_start = 1'b0;
        check("badkey_cycles", 64'(bad), 64'd4);
        check_state("cooldown_locked", ST_LOCKED);
        check_bal("cooldown_ignored");
        op(OP_UNLOCK, 32'hA5, '0);
        check_state("good_key", ST_UNLOCKED);
        op(OP_LOCK, 32'hA5, '0);

        // Round 3: masked bidder rejected, then reset in the middle of RESOLVE
        c_start = 1'b1;
        tick();
        bid = 4'b0011;
        bid_amt[0*DW +: DW] = 30;
        bid_amt[1*DW +: DW] = 5;
        #1;
        check("r3_ack", 64'(bid_ack), 64'h1);
        check("r3_bid_err", 64'(bid_err), 64'h4);
        tick();
        bid = '0; bid_amt = '0;
        exp_bal[0] -= 1;
        check_bal("r3_charge");
        c_start = 1'b0;
        tick();
        tick();
        check("r3_resolving", 64'(ready), 64'd0);
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) exp_bal[i] = '0;
        check_bal("midrst");
        check("midrst_ready", 64'(ready), 64'd1);
        check("midrst_round_over", 64'(round_over), 64'd0);
        check_state("midrst_state", ST_UNLOCKED);
        tick();
        reset_n = 1'b1;
        tick();
        check_state("post_rst_state", ST_UNLOCKED);
        check_bal("post_rst");
        check("post_rst_win", 64'(win), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
